// File: rtl/md_pkg.sv
// md_pkg: op encodings and FSM state codes shared by the multiply/divide scheduler.
package md_pkg;
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;
  localparam logic [2:0] MD_OP_MFHI  = 3'd6;
  localparam logic [2:0] MD_OP_MFLO  = 3'd7;
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_RUN  = 1'b1;
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 32x32 signed/unsigned multiply and divide, result as {hi, lo}.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);
  logic [63:0] smul, umul;
  logic signed [31:0] sa, sb, sbs, sq, sr;
  logic [31:0] ubs, uq, ur;
  logic ovf;
  assign smul = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign umul = {32'b0, a_i} * {32'b0, b_i};
  assign sa = a_i;
  assign sb = b_i;
  // Divisor forced nonzero so the div0 case never produces X; the result is discarded then.
  assign sbs = (b_i == 32'd0) ? 32'sd1 : sb;
  assign ubs = (b_i == 32'd0) ? 32'd1 : b_i;
  assign ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign sq = ovf ? sa : sa / sbs;
  assign sr = ovf ? 32'sd0 : sa % sbs;
  assign uq = a_i / ubs;
  assign ur = a_i % ubs;
  assign div0_o = (b_i == 32'd0);
  assign res_o = (op_i == MD_OP_MULT)  ? smul :
                 (op_i == MD_OP_MULTU) ? umul :
                 (op_i == MD_OP_DIV)   ? {sr, sq} : {ur, uq};
endmodule

// File: rtl/md_sched.sv
// md_sched: EX-stage mult/div sequencer owning HI/LO, with fixed latency and HI/LO-user stall.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_out,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic [63:0]      res_q, res_d, ares;
  logic             div0_q, div0_d, adiv0;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             idle, start, commit, wr, mt_ok;
  md_arith u_arith (
    .op_i  (op),
    .a_i   (src_a),
    .b_i   (src_b),
    .res_o (ares),
    .div0_o(adiv0)
  );
  assign idle   = (state_q == MD_IDLE);
  assign start  = op_valid & md_is_arith(op) & idle & ~cancel;
  assign commit = ~idle & (cnt_q == CNT_W'(1)) & ~cancel;
  assign wr     = commit & ~div0_q;
  assign mt_ok  = op_valid & idle & ~cancel;
  assign lat    = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  always_comb begin
    state_d = start ? MD_RUN : (~idle & (cancel | (cnt_q == CNT_W'(1)))) ? MD_IDLE : state_q;
    cnt_d   = start ? lat : (cancel | idle | (cnt_q == '0)) ? '0 : cnt_q - CNT_W'(1);
    res_d   = start ? ares : res_q;
    div0_d  = start ? adiv0 : div0_q;
    hi_d    = wr ? res_q[63:32] : (mt_ok & (op == MD_OP_MTHI)) ? src_a : hi_q;
    lo_d    = wr ? res_q[31:0] : (mt_ok & (op == MD_OP_MTLO)) ? src_a : lo_q;
    done_d  = commit;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  // A start cycle is IDLE, so only users arriving while RUN are held in EX.
  assign busy      = ~idle;
  assign stall_out = op_valid & busy;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = (op == MD_OP_MFHI) ? hi_q : (op == MD_OP_MFLO) ? lo_q : 32'd0;
endmodule
